// File: rtl/instr_fetch_queue_if.sv
// Purpose: bundles the instruction-memory request/response channel and the
//   decode-side valid/ready channel of the fetch queue.
// Signals:
//   imemReq/imemAddr      fetch request and address (fetch -> memory)
//   imemGnt               memory accepts the request this cycle
//   imemRspValid/Data     returned instruction word (memory -> fetch)
//   idValid/idInstr/idPC  head entry offered to decode (fetch -> decode)
//   idReady               decode consumes the head this cycle
// Handshake: a transfer happens on a rising edge where the producer's valid
//   (imemReq / idValid) and the consumer's accept (imemGnt / idReady) are both
//   high; a producer holds its payload until that transfer completes.
interface instr_fetch_queue_if;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemGnt;
  logic        imemRspValid;
  logic [31:0] imemRspData;
  logic        idValid;
  logic        idReady;
  logic [31:0] idInstr;
  logic [31:0] idPC;

  // master: the fetch queue itself
  modport master (
    output imemReq, imemAddr, idValid, idInstr, idPC,
    input  imemGnt, imemRspValid, imemRspData, idReady
  );

  // slave: the memory/decode environment around the queue
  modport slave (
    input  imemReq, imemAddr, idValid, idInstr, idPC,
    output imemGnt, imemRspValid, imemRspData, idReady
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// Purpose: fetch stage behind the PC. Issues one instruction-memory request at a
//   time, buffers returned instructions with their PC in a DEPTH-entry FIFO and
//   presents the head to decode. Pulses pcAdvance when a request is accepted.
//   flush discards the buffered entries and any in-flight fetch.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   pcIn        current PC; used directly as the fetch address
//   pcAdvance   request accepted this cycle (control selects PC+4)
//   flush       redirect; kills the queue and the outstanding fetch
//   bus         memory and decode channels (instr_fetch_queue_if.master)
//   dbgCount    current queue occupancy, for observation only
module instr_fetch_queue #(
  parameter int          DEPTH = 2,
  parameter logic [31:0] NOP   = 32'h00000013
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [31:0]                  pcIn,
  output logic                         pcAdvance,
  input  logic                         flush,
  instr_fetch_queue_if.master          bus,
  output logic [$clog2(DEPTH+1)-1:0]   dbgCount
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic          outstanding_q, outstanding_d;
  logic          drop_q, drop_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   pc_q    [DEPTH];

  logic issue, accept, rsp_take, push, pop, not_empty;

  // Only one fetch can be in flight, so "no outstanding and not full" is the
  // same as reserving a queue slot for the request being issued.
  assign not_empty = (count_q != '0);
  assign issue     = !reset && !flush && !outstanding_q && (count_q != CW'(DEPTH));
  assign accept    = issue && bus.imemGnt;
  assign rsp_take  = bus.imemRspValid && outstanding_q;
  // A response that belongs to a killed fetch (drop) or that arrives during a
  // flush is consumed but never written.
  assign push      = rsp_take && !drop_q && !flush;
  assign pop       = not_empty && bus.idReady;

  assign bus.imemReq  = issue;
  assign bus.imemAddr = pcIn;
  assign pcAdvance    = accept;
  assign bus.idValid  = not_empty;
  assign bus.idInstr  = not_empty ? instr_q[rd_ptr_q] : NOP;
  assign bus.idPC     = not_empty ? pc_q[rd_ptr_q]    : 32'h0;
  assign dbgCount     = count_q;

  always_comb begin
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    req_pc_d      = req_pc_q;

    if (flush) begin
      // Flush wins over push/pop; the read pointer jumps to the write pointer
      // so the queue is empty without touching the storage.
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (!push && pop) count_d = count_q - CW'(1);
    end

    if (accept) begin
      outstanding_d = 1'b1;
      req_pc_d      = pcIn;
    end else if (rsp_take) begin
      outstanding_d = 1'b0;
    end

    if (rsp_take)                    drop_d = 1'b0;
    else if (flush && outstanding_q) drop_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
      req_pc_q      <= 32'h0;
    end else begin
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      req_pc_q      <= req_pc_d;
    end
  end

  // Storage is never read while its entry is not counted, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      instr_q[wr_ptr_q] <= bus.imemRspData;
      pc_q[wr_ptr_q]    <= req_pc_q;
    end
  end

endmodule
